// File: rtl/sobel_window_gen.sv
// 3x3 Sobel window generator: two line buffers plus a shift window over a raster stream.
// Optional macro SOBEL_WIN_SOF_EN adds a sof input that forces the current pixel to (0,0).
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [7:0]  pix_in,
`ifdef SOBEL_WIN_SOF_EN
    input  logic        sof,
`endif
    output logic [7:0]  pixel_00,
    output logic [7:0]  pixel_01,
    output logic [7:0]  pixel_02,
    output logic [7:0]  pixel_10,
    output logic [7:0]  pixel_11,
    output logic [7:0]  pixel_12,
    output logic [7:0]  pixel_20,
    output logic [7:0]  pixel_21,
    output logic [7:0]  pixel_22,
    output logic        win_valid,
    output logic [15:0] win_x,
    output logic [15:0] win_y
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb1 [IMG_WIDTH];
    logic [7:0]    r_lb2 [IMG_WIDTH];
    logic [7:0]    r_h1  [3];
    logic [7:0]    r_h2  [3];

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_win;
    logic [7:0]    w_new [3];

    // A sof pixel overrides the counters so it is processed as (0,0).
`ifdef SOBEL_WIN_SOF_EN
    assign w_col = sof ? '0 : r_col;
    assign w_row = sof ? '0 : r_row;
`else
    assign w_col = r_col;
    assign w_row = r_row;
`endif

    assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
    assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));
    assign w_win      = pix_valid && (w_col >= CW'(2)) && (w_row >= RW'(2));

    assign w_new[0] = r_lb2[w_col];
    assign w_new[1] = r_lb1[w_col];
    assign w_new[2] = pix_in;

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb2[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            r_col <= w_last_col ? '0 : w_col + CW'(1);
            if (w_last_col)
                r_row <= w_last_row ? '0 : w_row + RW'(1);
            else
                r_row <= w_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_h1[i] <= '0;
                r_h2[i] <= '0;
            end
        end else if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                r_h2[i] <= r_h1[i];
                r_h1[i] <= w_new[i];
            end
        end
    end

    // Outputs only load on a complete window so they hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            pixel_00  <= '0;
            pixel_01  <= '0;
            pixel_02  <= '0;
            pixel_10  <= '0;
            pixel_11  <= '0;
            pixel_12  <= '0;
            pixel_20  <= '0;
            pixel_21  <= '0;
            pixel_22  <= '0;
        end else begin
            win_valid <= w_win;
            if (w_win) begin
                win_x    <= 16'(w_col) - 16'd1;
                win_y    <= 16'(w_row) - 16'd1;
                pixel_00 <= r_h2[0];
                pixel_01 <= r_h1[0];
                pixel_02 <= w_new[0];
                pixel_10 <= r_h2[1];
                pixel_11 <= r_h1[1];
                pixel_12 <= w_new[1];
                pixel_20 <= r_h2[2];
                pixel_21 <= r_h1[2];
                pixel_22 <= w_new[2];
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on an 8x6 image, pixel value = row*16+col.
// Optional sof test is compiled when SOBEL_WIN_SOF_EN is defined.
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int x;
        int y;
    } win_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in = '0;
`ifdef SOBEL_WIN_SOF_EN
    logic        sof = 1'b0;
`endif
    logic [7:0]  pixel_00, pixel_01, pixel_02;
    logic [7:0]  pixel_10, pixel_11, pixel_12;
    logic [7:0]  pixel_20, pixel_21, pixel_22;
    logic        win_valid;
    logic [15:0] win_x, win_y;
    logic [7:0]  obs [9];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_win   = 0;
    int   last_x  = 0;
    int   last_y  = 0;
    int   last_p11 = 0;
    win_t sb [$];

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_valid(pix_valid),
        .pix_in   (pix_in),
`ifdef SOBEL_WIN_SOF_EN
        .sof      (sof),
`endif
        .pixel_00 (pixel_00),
        .pixel_01 (pixel_01),
        .pixel_02 (pixel_02),
        .pixel_10 (pixel_10),
        .pixel_11 (pixel_11),
        .pixel_12 (pixel_12),
        .pixel_20 (pixel_20),
        .pixel_21 (pixel_21),
        .pixel_22 (pixel_22),
        .win_valid(win_valid),
        .win_x    (win_x),
        .win_y    (win_y)
    );

    always_comb obs = '{pixel_00, pixel_01, pixel_02,
                        pixel_10, pixel_11, pixel_12,
                        pixel_20, pixel_21, pixel_22};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        check("idle_valid", int'(win_valid), 0);
    endtask

    task automatic send(input int c, input int r);
        win_t e;
        bit   expw;
        expw = (c >= 2) && (r >= 2);
        pix_valid = 1'b1;
        pix_in    = 8'(r * 16 + c);
        if (expw) begin
            e.x = c - 1;
            e.y = r - 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
`ifdef SOBEL_WIN_SOF_EN
        sof = 1'b0;
`endif
        check($sformatf("valid_%0d_%0d", c, r), int'(win_valid), int'(expw));
        if (win_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                n_win++;
                check("win_x", int'(win_x), e.x);
                check("win_y", int'(win_y), e.y);
                for (int i = 0; i < 9; i++)
                    check($sformatf("pix%0d%0d@%0d,%0d", i / 3, i % 3, e.x, e.y),
                          int'(obs[i]),
                          (e.y - 1 + i / 3) * 16 + (e.x - 1 + i % 3));
                last_x   = e.x;
                last_y   = e.y;
                last_p11 = e.y * 16 + e.x;
            end
        end else begin
            check("hold_x", int'(win_x), last_x);
            check("hold_y", int'(win_y), last_y);
            check("hold_p11", int'(pixel_11), last_p11);
        end
    endtask

    task automatic send_frame(input bit gaps, input int first);
        for (int k = first; k < W * H; k++) begin
            if (gaps)
                repeat ($urandom_range(1, 3)) idle();
            send(k % W, k / W);
        end
    endtask

    initial begin
        #12;
        check("rst_valid", int'(win_valid), 0);
        check("rst_x", int'(win_x), 0);
        check("rst_y", int'(win_y), 0);
        for (int i = 0; i < 9; i++)
            check($sformatf("rst_pix%0d", i), int'(obs[i]), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        n_win = 0;
        send_frame(1'b0, 0);
        check("frame1_wins", n_win, 24);
        check("frame1_last_x", last_x, 6);
        check("frame1_last_y", last_y, 4);
        check("frame1_last_p22", int'(pixel_22), 8'h57);

        n_win = 0;
        send_frame(1'b1, 0);
        check("gap_wins", n_win, 24);

        n_win = 0;
        send_frame(1'b0, 0);
        send_frame(1'b0, 0);
        check("b2b_wins", n_win, 48);

        for (int k = 0; k < 30; k++)
            send(k % W, k / W);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(win_valid), 0);
        check("mid_rst_x", int'(win_x), 0);
        check("mid_rst_y", int'(win_y), 0);
        for (int i = 0; i < 9; i++)
            check($sformatf("mid_rst_pix%0d", i), int'(obs[i]), 0);
        check("mid_rst_sb", sb.size(), 0);
        sb.delete();
        last_x = 0;
        last_y = 0;
        last_p11 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_win = 0;
        send_frame(1'b0, 0);
        check("post_rst_wins", n_win, 24);

`ifdef SOBEL_WIN_SOF_EN
        for (int k = 0; k < 19; k++)
            send(k % W, k / W);
        n_win = 0;
        sof = 1'b1;
        send(0, 0);
        send_frame(1'b0, 1);
        check("sof_wins", n_win, 24);
`endif

        idle();
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
